// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between three requesting masters, the arbiter and the single memory slave port.
// Handshake: a request is held until its grant pulse, and the response follows as a one-cycle rvalid strobe.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [2:0]      m_req;
    logic [2:0]      m_we;
    logic [3*AW-1:0] m_addr;
    logic [3*DW-1:0] m_wdata;
    logic [2:0]      m_gnt;
    logic [2:0]      m_rvalid;
    logic [DW-1:0]   m_rdata;
    logic            m_err;

    logic            s_req;
    logic            s_we;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata;
    logic            s_gnt;
    logic            s_rvalid;
    logic [DW-1:0]   s_rdata;

    modport arbiter (
        input  m_req, m_we, m_addr, m_wdata,
        output m_gnt, m_rvalid, m_rdata, m_err,
        output s_req, s_we, s_addr, s_wdata,
        input  s_gnt, s_rvalid, s_rdata
    );

    modport master (
        output m_req, m_we, m_addr, m_wdata,
        input  m_gnt, m_rvalid, m_rdata, m_err
    );

    modport slave (
        input  s_req, s_we, s_addr, s_wdata,
        output s_gnt, s_rvalid, s_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Three-master single-port memory arbiter: debug has fixed priority, core data/ifetch share round-robin,
// one transfer outstanding, with a response timeout that returns an error strobe.
module mem_port_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int TO_CYCLES = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dbg_lock,
    mem_port_arbiter_if.arbiter bus,
    output logic                busy,
    output logic [1:0]          cur_id,
    output logic [1:0]          state_dbg,
    output logic                rr_dbg
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TO_CYCLES - 1);

    state_t        state_q, state_d;
    logic [1:0]    id_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [15:0]   cnt_q;
    // rr_q = 1 means master 2 was served last, so master 1 is preferred next.
    logic          rr_q;

    logic [2:0]    elig;
    logic          win_valid;
    logic [1:0]    win_id;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;
    logic          timeout;
    logic [2:0]    id_onehot;

    always_comb begin
        elig      = bus.m_req & {~dbg_lock, ~dbg_lock, 1'b1};
        win_valid = |elig;
        if (elig[0]) begin
            win_id = 2'd0;
        end else if (elig[1] && elig[2]) begin
            win_id = rr_q ? 2'd1 : 2'd2;
        end else if (elig[1]) begin
            win_id = 2'd1;
        end else begin
            win_id = 2'd2;
        end
    end

    always_comb begin
        case (win_id)
            2'd1: begin
                win_we    = bus.m_we[1];
                win_addr  = bus.m_addr[AW +: AW];
                win_wdata = bus.m_wdata[DW +: DW];
            end
            2'd2: begin
                win_we    = bus.m_we[2];
                win_addr  = bus.m_addr[2*AW +: AW];
                win_wdata = bus.m_wdata[2*DW +: DW];
            end
            default: begin
                win_we    = bus.m_we[0];
                win_addr  = bus.m_addr[0 +: AW];
                win_wdata = bus.m_wdata[0 +: DW];
            end
        endcase
    end

    assign timeout   = (cnt_q == TO_LAST);
    assign id_onehot = 3'b001 << id_q;

    // Slave handshakes win over a coinciding timeout; IDLE ignores stray slave strobes.
    always_comb begin
        state_d      = state_q;
        bus.m_gnt    = 3'b000;
        bus.m_rvalid = 3'b000;
        bus.m_rdata  = '0;
        bus.m_err    = 1'b0;
        bus.s_req    = 1'b0;
        bus.s_we     = 1'b0;
        bus.s_addr   = '0;
        bus.s_wdata  = '0;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d = ADDR;
                end
            end
            ADDR: begin
                bus.s_req   = 1'b1;
                bus.s_we    = we_q;
                bus.s_addr  = addr_q;
                bus.s_wdata = wdata_q;
                if (bus.s_gnt) begin
                    bus.m_gnt = id_onehot;
                    state_d   = DATA;
                end else if (timeout) begin
                    bus.m_rvalid = id_onehot;
                    bus.m_err    = 1'b1;
                    state_d      = IDLE;
                end
            end
            DATA: begin
                if (bus.s_rvalid) begin
                    bus.m_rvalid = id_onehot;
                    bus.m_rdata  = bus.s_rdata;
                    state_d      = IDLE;
                end else if (timeout) begin
                    bus.m_rvalid = id_onehot;
                    bus.m_err    = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            id_q    <= 2'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rr_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && win_valid) begin
                id_q    <= win_id;
                we_q    <= win_we;
                addr_q  <= win_addr;
                wdata_q <= win_wdata;
            end
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (state_q != IDLE) begin
                cnt_q <= cnt_q + 16'd1;
            end
            if (state_q == ADDR && bus.s_gnt && id_q != 2'd0) begin
                rr_q <= (id_q == 2'd2);
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign cur_id    = (state_q == IDLE) ? 2'd0 : id_q;
    assign state_dbg = state_q;
    assign rr_dbg    = rr_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: priority, round-robin, debug lock, timeout and reset abandonment.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       dbg_lock;
    logic       busy;
    logic [1:0] cur_id;
    logic [1:0] state_dbg;
    logic       rr_dbg;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .TO_CYCLES(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .dbg_lock  (dbg_lock),
        .bus       (bus),
        .busy      (busy),
        .cur_id    (cur_id),
        .state_dbg (state_dbg),
        .rr_dbg    (rr_dbg)
    );

    always #5 clk = ~clk;

    // Slave model: accepts combinationally when enabled, answers one cycle after the accept.
    logic          slave_gnt_en;
    logic          slave_rv_en;
    logic          force_rv;
    logic          rv_q;
    logic [DW-1:0] rdata_val;

    assign bus.s_gnt    = bus.s_req & slave_gnt_en;
    assign bus.s_rvalid = rv_q | force_rv;
    assign bus.s_rdata  = rdata_val;

    always @(posedge clk or negedge rst) begin
        if (!rst) rv_q <= 1'b0;
        else      rv_q <= bus.s_req & bus.s_gnt & slave_rv_en;
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic drop_on_gnt;
    logic [2:0] gnt_prev;

    int            gnt_id_q[$];
    int            gnt_cyc_q[$];
    logic [AW-1:0] acc_addr_q[$];
    logic          acc_we_q[$];
    logic [DW-1:0] acc_wdata_q[$];
    int            rv_id_q[$];
    int            rv_cyc_q[$];
    logic          rv_err_q[$];
    logic [DW-1:0] rv_data_q[$];
    logic          rv_rr_q[$];
    logic [31:0]   exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int oh_to_id(input logic [2:0] v);
        return v[2] ? 2 : (v[1] ? 1 : 0);
    endfunction

    always @(negedge clk) begin
        gnt_prev = bus.m_gnt;
        if (rst) begin
            if (bus.m_gnt != 3'b000) begin
                check("gnt_onehot", 64'($onehot(bus.m_gnt)), 64'd1);
                gnt_id_q.push_back(oh_to_id(bus.m_gnt));
                gnt_cyc_q.push_back(cyc);
                acc_addr_q.push_back(bus.s_addr);
                acc_we_q.push_back(bus.s_we);
                acc_wdata_q.push_back(bus.s_wdata);
            end
            if (bus.m_rvalid != 3'b000) begin
                check("rv_onehot", 64'($onehot(bus.m_rvalid)), 64'd1);
                rv_id_q.push_back(oh_to_id(bus.m_rvalid));
                rv_cyc_q.push_back(cyc);
                rv_err_q.push_back(bus.m_err);
                rv_data_q.push_back(bus.m_rdata);
                rv_rr_q.push_back(rr_dbg);
            end else begin
                check("quiet_rdata", 64'(bus.m_rdata), 64'd0);
                check("quiet_err", 64'(bus.m_err), 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (drop_on_gnt) bus.m_req = bus.m_req & ~gnt_prev;
    endtask

    task automatic clear_logs();
        gnt_id_q.delete();   gnt_cyc_q.delete();
        acc_addr_q.delete(); acc_we_q.delete(); acc_wdata_q.delete();
        rv_id_q.delete();    rv_cyc_q.delete(); rv_err_q.delete();
        rv_data_q.delete();  rv_rr_q.delete();  exp_q.delete();
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        bus.m_req = 3'b000;
        force_rv = 1'b0;
        dbg_lock = 1'b0;
        tick();
        tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_state", 64'(state_dbg), 64'd0);
        check("rst_cur_id", 64'(cur_id), 64'd0);
        check("rst_rr", 64'(rr_dbg), 64'd1);
        check("rst_s_req", 64'(bus.s_req), 64'd0);
        check("rst_m_gnt", 64'(bus.m_gnt), 64'd0);
        check("rst_m_rvalid", 64'(bus.m_rvalid), 64'd0);
        rst = 1'b1;
        tick();
        clear_logs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        dbg_lock      = 1'b0;
        bus.m_req     = 3'b000;
        bus.m_we      = 3'b000;
        bus.m_addr    = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
        bus.m_wdata   = {32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
        slave_gnt_en  = 1'b0;
        slave_rv_en   = 1'b0;
        force_rv      = 1'b0;
        rdata_val     = '0;
        drop_on_gnt   = 1'b0;

        // Fixed priority then round-robin with all three requesting.
        do_reset();
        slave_gnt_en = 1'b1; slave_rv_en = 1'b1; drop_on_gnt = 1'b1;
        start = cyc;
        bus.m_req = 3'b111;
        repeat (12) tick();
        check("t1_gnt_count", 64'(gnt_id_q.size()), 64'd3);
        check("t1_rv_count", 64'(rv_id_q.size()), 64'd3);
        exp_q = '{32'd0, 32'd1, 32'd2};
        for (int i = 0; i < 3; i++) begin
            check("t1_gnt_id", 64'(i < gnt_id_q.size() ? gnt_id_q[i] : -1), 64'(exp_q[i]));
            check("t1_gnt_cyc", 64'(i < gnt_cyc_q.size() ? gnt_cyc_q[i] : -1), 64'(start + 1 + 3*i));
            check("t1_addr", 64'(i < acc_addr_q.size() ? acc_addr_q[i] : '1), 64'((exp_q[i] + 1) * 32'h100));
            check("t1_rv_id", 64'(i < rv_id_q.size() ? rv_id_q[i] : -1), 64'(exp_q[i]));
            check("t1_rv_cyc", 64'(i < rv_cyc_q.size() ? rv_cyc_q[i] : -1), 64'(start + 2 + 3*i));
            check("t1_rv_err", 64'(i < rv_err_q.size() ? rv_err_q[i] : 1'b1), 64'd0);
        end
        check("t1_rr_end", 64'(rr_dbg), 64'd1);

        // Masters 1 and 2 held: strict alternation starting with 1.
        do_reset();
        slave_gnt_en = 1'b1; slave_rv_en = 1'b1; drop_on_gnt = 1'b0;
        start = cyc;
        bus.m_req = 3'b110;
        for (int i = 0; i < 40 && gnt_id_q.size() < 4; i++) tick();
        bus.m_req = 3'b000;
        repeat (4) tick();
        check("t2_gnt_count", 64'(gnt_id_q.size()), 64'd4);
        exp_q = '{32'd1, 32'd2, 32'd1, 32'd2};
        for (int i = 0; i < 4; i++) begin
            check("t2_gnt_id", 64'(i < gnt_id_q.size() ? gnt_id_q[i] : -1), 64'(exp_q[i]));
            check("t2_gnt_cyc", 64'(i < gnt_cyc_q.size() ? gnt_cyc_q[i] : -1), 64'(start + 1 + 3*i));
            check("t2_rr", 64'(i < rv_rr_q.size() ? rv_rr_q[i] : 1'bx), 64'(exp_q[i] == 32'd2));
        end

        // Debug lock blocks cores; debug itself still served, cores resume after unlock.
        do_reset();
        slave_gnt_en = 1'b1; slave_rv_en = 1'b1; drop_on_gnt = 1'b1;
        dbg_lock = 1'b1;
        bus.m_req = 3'b110;
        repeat (20) tick();
        check("t3_locked_gnts", 64'(gnt_id_q.size()), 64'd0);
        check("t3_locked_busy", 64'(busy), 64'd0);
        start = cyc;
        bus.m_req = 3'b111;
        repeat (20) tick();
        check("t3_dbg_gnts", 64'(gnt_id_q.size()), 64'd1);
        check("t3_dbg_id", 64'(gnt_id_q.size() > 0 ? gnt_id_q[0] : -1), 64'd0);
        check("t3_dbg_cyc", 64'(gnt_cyc_q.size() > 0 ? gnt_cyc_q[0] : -1), 64'(start + 1));
        check("t3_dbg_rv", 64'(rv_id_q.size()), 64'd1);
        dbg_lock = 1'b0;
        repeat (3) tick();
        check("t3_unlock_id", 64'(gnt_id_q.size() > 1 ? gnt_id_q[1] : -1), 64'd1);
        bus.m_req = 3'b000;
        repeat (6) tick();

        // Response timeout in DATA: error strobe 7 cycles after DATA entry.
        do_reset();
        slave_gnt_en = 1'b1; slave_rv_en = 1'b0; drop_on_gnt = 1'b1;
        rdata_val = 32'hDEAD_BEEF;
        start = cyc;
        bus.m_req = 3'b010;
        repeat (12) tick();
        check("t4_gnt_cyc", 64'(gnt_cyc_q.size() > 0 ? gnt_cyc_q[0] : -1), 64'(start + 1));
        check("t4_rv_count", 64'(rv_id_q.size()), 64'd1);
        check("t4_rv_id", 64'(rv_id_q.size() > 0 ? rv_id_q[0] : -1), 64'd1);
        check("t4_rv_cyc", 64'(rv_cyc_q.size() > 0 ? rv_cyc_q[0] : -1), 64'(start + 2 + 7));
        check("t4_err", 64'(rv_err_q.size() > 0 ? rv_err_q[0] : 1'b0), 64'd1);
        check("t4_rdata", 64'(rv_data_q.size() > 0 ? rv_data_q[0] : '1), 64'd0);
        check("t4_busy", 64'(busy), 64'd0);

        // Timeout while waiting for accept in ADDR; no grant, rr untouched.
        clear_logs();
        slave_gnt_en = 1'b0;
        start = cyc;
        bus.m_req = 3'b100;
        while (cyc < start + 8) tick();
        bus.m_req = 3'b000;
        repeat (4) tick();
        check("t4b_gnts", 64'(gnt_id_q.size()), 64'd0);
        check("t4b_rv_id", 64'(rv_id_q.size() > 0 ? rv_id_q[0] : -1), 64'd2);
        check("t4b_rv_cyc", 64'(rv_cyc_q.size() > 0 ? rv_cyc_q[0] : -1), 64'(start + 8));
        check("t4b_err", 64'(rv_err_q.size() > 0 ? rv_err_q[0] : 1'b0), 64'd1);
        check("t4b_rr", 64'(rr_dbg), 64'd0);

        // Response landing exactly on the timeout cycle completes normally.
        clear_logs();
        slave_gnt_en = 1'b1;
        start = cyc;
        bus.m_req = 3'b010;
        while (cyc < start + 9) tick();
        force_rv = 1'b1;
        tick();
        force_rv = 1'b0;
        repeat (3) tick();
        check("t4c_rv_count", 64'(rv_id_q.size()), 64'd1);
        check("t4c_rv_cyc", 64'(rv_cyc_q.size() > 0 ? rv_cyc_q[0] : -1), 64'(start + 9));
        check("t4c_err", 64'(rv_err_q.size() > 0 ? rv_err_q[0] : 1'b1), 64'd0);
        check("t4c_rdata", 64'(rv_data_q.size() > 0 ? rv_data_q[0] : '0), 64'h0000_0000_DEAD_BEEF);

        // Read of 0x10 and a write, with data path checks.
        clear_logs();
        slave_gnt_en = 1'b1; slave_rv_en = 1'b1;
        bus.m_addr  = {32'h0000_0020, 32'h0000_0010, 32'h0000_0000};
        bus.m_wdata = {32'hCAFE_F00D, 32'h1111_1111, 32'h0000_0000};
        bus.m_we    = 3'b100;
        rdata_val   = 32'hDEAD_BEEF;
        bus.m_req   = 3'b010;
        repeat (5) tick();
        rdata_val   = 32'h0;
        bus.m_req   = 3'b100;
        repeat (5) tick();
        check("t5_count", 64'(rv_id_q.size()), 64'd2);
        check("t5_rd_addr", 64'(acc_addr_q.size() > 0 ? acc_addr_q[0] : '1), 64'h10);
        check("t5_rd_we", 64'(acc_we_q.size() > 0 ? acc_we_q[0] : 1'b1), 64'd0);
        check("t5_rd_data", 64'(rv_data_q.size() > 0 ? rv_data_q[0] : '0), 64'h0000_0000_DEAD_BEEF);
        check("t5_rd_err", 64'(rv_err_q.size() > 0 ? rv_err_q[0] : 1'b1), 64'd0);
        check("t5_wr_addr", 64'(acc_addr_q.size() > 1 ? acc_addr_q[1] : '1), 64'h20);
        check("t5_wr_we", 64'(acc_we_q.size() > 1 ? acc_we_q[1] : 1'b0), 64'd1);
        check("t5_wr_wdata", 64'(acc_wdata_q.size() > 1 ? acc_wdata_q[1] : '0), 64'h0000_0000_CAFE_F00D);
        check("t5_wr_id", 64'(rv_id_q.size() > 1 ? rv_id_q[1] : -1), 64'd2);
        bus.m_we = 3'b000;

        // Reset during DATA abandons the transfer; late response is ignored.
        do_reset();
        slave_gnt_en = 1'b1; slave_rv_en = 1'b0; drop_on_gnt = 1'b1;
        start = cyc;
        bus.m_req = 3'b010;
        while (cyc < start + 2) tick();
        check("t6_in_data", 64'(state_dbg), 64'd2);
        check("t6_busy_pre", 64'(busy), 64'd1);
        check("t6_cur_id", 64'(cur_id), 64'd1);
        rst = 1'b0;
        bus.m_req = 3'b000;
        #1;
        check("t6_rst_state", 64'(state_dbg), 64'd0);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_cur_id", 64'(cur_id), 64'd0);
        check("t6_rst_rvalid", 64'(bus.m_rvalid), 64'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        force_rv = 1'b1;
        tick();
        force_rv = 1'b0;
        repeat (3) tick();
        check("t6_no_rvalid", 64'(rv_id_q.size()), 64'd0);
        check("t6_state", 64'(state_dbg), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
